// File: rtl/fpu_issue_scheduler.sv
// Issue scheduler for multi-cycle FPU ops: start pulse, latency count, ID stall on hazards, writeback strobe.
// Optional stall-cycle performance counter enabled by defining FPU_SCHED_PERF_EN.
module fpu_issue_scheduler #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 3,
  parameter int LAT_DIV  = 10,
  parameter int LAT_SQRT = 14,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fpu_issue_id,
  input  logic [6:0]  funct7_id,
  input  logic [4:0]  rd_id,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        rs1_fpu_id,
  input  logic        rs2_fpu_id,
  input  logic        fwr_id,
  input  logic        flush,
  output logic        stall_id,
  output logic        fpu_start,
  output logic [1:0]  fpu_op,
  output logic        fpu_abort,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        busy,
  output logic [31:0] perf_stall_cnt
);

  localparam logic [6:0] F7_ADD  = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0000100;
  localparam logic [6:0] F7_MUL  = 7'b0001000;
  localparam logic [6:0] F7_DIV  = 7'b0001100;
  localparam logic [6:0] F7_SQRT = 7'b0101100;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       pend_rd_q, pend_rd_d;

  logic             mc;
  logic [1:0]       op_class;
  logic [CNT_W-1:0] lat_m1;
  logic             done;
  logic             hazard;
  logic             start;

  always_comb begin
    mc       = 1'b0;
    op_class = 2'd0;
    lat_m1   = '0;
    case (funct7_id)
      F7_ADD, F7_SUB: begin
        mc = fpu_issue_id; op_class = 2'd0; lat_m1 = CNT_W'(LAT_ADD - 1);
      end
      F7_MUL: begin
        mc = fpu_issue_id; op_class = 2'd1; lat_m1 = CNT_W'(LAT_MUL - 1);
      end
      F7_DIV: begin
        mc = fpu_issue_id; op_class = 2'd2; lat_m1 = CNT_W'(LAT_DIV - 1);
      end
      F7_SQRT: begin
        mc = fpu_issue_id; op_class = 2'd3; lat_m1 = CNT_W'(LAT_SQRT - 1);
      end
      default: ;
    endcase
  end

  assign busy = (state_q == EXEC);
  assign done = busy & (cnt_q == '0);

  // The pending destination is released in the done cycle so a dependent op issues with no bubble.
  assign hazard = busy & ~done & ((rs1_fpu_id & (rs1_id == pend_rd_q)) |
                                  (rs2_fpu_id & (rs2_id == pend_rd_q)) |
                                  (fwr_id & (rd_id == pend_rd_q)) | mc);
  assign stall_id  = hazard & ~flush;
  assign start     = mc & ~flush & (~busy | done);
  assign fpu_start = start;
  assign fpu_op    = start ? op_class : 2'd0;
  assign fpu_abort = busy & flush;
  assign wb_valid  = done & ~flush;
  assign wb_rd     = wb_valid ? pend_rd_q : 5'd0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    if (busy) begin
      if (flush) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (done) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    if (start) begin
      state_d   = EXEC;
      cnt_d     = lat_m1;
      pend_rd_d = rd_id;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_rd_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_rd_q <= pend_rd_d;
    end
  end

`ifdef FPU_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (stall_id && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) perf_q <= 32'd0;
    else       perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// Bench for fpu_issue_scheduler: directed scenarios plus random traffic checked against a
// timestamp-based model (each op's writeback cycle = start cycle + latency).
module tb_fpu_issue_scheduler;

  localparam logic [6:0] F_ADD  = 7'b0000000;
  localparam logic [6:0] F_SUB  = 7'b0000100;
  localparam logic [6:0] F_MUL  = 7'b0001000;
  localparam logic [6:0] F_DIV  = 7'b0001100;
  localparam logic [6:0] F_SQRT = 7'b0101100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fpu_issue_id = 1'b0;
  logic [6:0]  funct7_id = 7'd0;
  logic [4:0]  rd_id = 5'd0, rs1_id = 5'd0, rs2_id = 5'd0;
  logic        rs1_fpu_id = 1'b0, rs2_fpu_id = 1'b0, fwr_id = 1'b0, flush = 1'b0;
  logic        stall_id, fpu_start, fpu_abort, wb_valid, busy;
  logic [1:0]  fpu_op;
  logic [4:0]  wb_rd;
  logic [31:0] perf_stall_cnt;

  always #5 clk = ~clk;

  fpu_issue_scheduler dut (
    .clk(clk), .rstn(rstn), .fpu_issue_id(fpu_issue_id), .funct7_id(funct7_id),
    .rd_id(rd_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_fpu_id(rs1_fpu_id),
    .rs2_fpu_id(rs2_fpu_id), .fwr_id(fwr_id), .flush(flush), .stall_id(stall_id),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_abort(fpu_abort), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .busy(busy), .perf_stall_cnt(perf_stall_cnt)
  );

  logic [11:0] obs;
  assign obs = {stall_id, fpu_start, fpu_op, fpu_abort, wb_valid, wb_rd, busy};

  int checks = 0;
  int passed = 0;

  // Reference model: one op in flight, identified by the absolute cycle of its writeback.
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_wb_cyc = 0;
  logic [4:0]  m_rd = 5'd0;
  bit          n_busy;
  int          n_wb_cyc;
  logic [4:0]  n_rd;
  bit          exp_stall;
  logic [11:0] exp_v;
  logic [31:0] exp_perf = 32'd0;

  logic [6:0] f7_tab [7] = '{F_ADD, F_SUB, F_MUL, F_DIV, F_SQRT, 7'b0010000, 7'b1101000};

  function automatic int lat_of(input logic [6:0] f7, output logic [1:0] cls);
    cls = 2'd0;
    case (f7)
      F_ADD, F_SUB: return 2;
      F_MUL:  begin cls = 2'd1; return 3;  end
      F_DIV:  begin cls = 2'd2; return 10; end
      F_SQRT: begin cls = 2'd3; return 14; end
      default: return 0;
    endcase
  endfunction

  task automatic model_eval();
    int lat;
    logic [1:0] cls;
    bit mc, done, hz, st;
    lat  = lat_of(funct7_id, cls);
    mc   = fpu_issue_id && (lat > 0);
    done = m_busy && (cyc == m_wb_cyc);
    hz   = m_busy && !done && ((rs1_fpu_id && rs1_id == m_rd) || (rs2_fpu_id && rs2_id == m_rd) ||
                               (fwr_id && rd_id == m_rd) || mc);
    st   = mc && !flush && (!m_busy || done);
    exp_stall = hz && !flush;
    exp_v = {exp_stall, st, st ? cls : 2'd0, m_busy && flush, done && !flush,
             (done && !flush) ? m_rd : 5'd0, m_busy};
    n_busy = m_busy; n_wb_cyc = m_wb_cyc; n_rd = m_rd;
    if (st) begin
      n_busy = 1'b1; n_wb_cyc = cyc + lat; n_rd = rd_id;
    end else if (m_busy && (flush || done)) begin
      n_busy = 1'b0;
    end
  endtask

  task automatic begin_cycle(input bit iss, input logic [6:0] f7, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input bit r1f,
                             input bit r2f, input bit fw, input bit fl);
    @(negedge clk);
    fpu_issue_id = iss; funct7_id = f7; rd_id = rd; rs1_id = rs1; rs2_id = rs2;
    rs1_fpu_id = r1f; rs2_fpu_id = r2f; fwr_id = fw; flush = fl;
    #1;
    model_eval();
  endtask

  task automatic begin_idle();
    begin_cycle(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic end_cycle();
    @(posedge clk);
    m_busy = n_busy; m_wb_cyc = n_wb_cyc; m_rd = n_rd;
    if (exp_stall && exp_perf != 32'hFFFF_FFFF) exp_perf = exp_perf + 32'd1;
    cyc++;
  endtask

  function automatic logic [31:0] perf_expected();
`ifdef FPU_SCHED_PERF_EN
    return exp_perf;
`else
    return 32'd0;
`endif
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== 12'h000 || perf_stall_cnt !== 32'd0)
        $display("FAIL reset got=%h perf=%0d exp=000 perf=0", obs, perf_stall_cnt);
      else passed++;
    end
    #2 rstn = 1'b1;
    m_busy = 1'b0; m_rd = 5'd0; exp_perf = 32'd0; cyc = 0;
  endtask

  task automatic test_fdiv_latency();
    int wb_at = -1;
    logic [4:0] rd_seen = 5'd0;
    begin_cycle(1'b1, F_DIV, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_v || fpu_start !== 1'b1 || fpu_op !== 2'd2)
      $display("FAIL fdiv_start got=%h exp=%h", obs, exp_v);
    else passed++;
    end_cycle();
    for (int i = 1; i <= 12; i++) begin
      begin_idle();
      checks++;
      if (obs !== exp_v) $display("FAIL fdiv_seq i=%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      if (wb_valid === 1'b1 && wb_at < 0) begin wb_at = i; rd_seen = wb_rd; end
      end_cycle();
    end
    checks++;
    if (wb_at !== 10 || rd_seen !== 5'd3)
      $display("FAIL fdiv_latency got=%0d rd=%0d exp=10 rd=3", wb_at, rd_seen);
    else passed++;
  endtask

  task automatic test_raw_stall();
    int stalls = 0;
    bit started = 1'b0, same = 1'b0;
    begin_cycle(1'b1, F_DIV, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_v) $display("FAIL raw_div got=%h exp=%h", obs, exp_v); else passed++;
    end_cycle();
    for (int i = 0; i < 20 && !started; i++) begin
      begin_cycle(1'b1, F_ADD, 5'd4, 5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_v) $display("FAIL raw_seq i=%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      if (stall_id === 1'b1) stalls++;
      if (fpu_start === 1'b1) begin started = 1'b1; same = (wb_valid === 1'b1) && (wb_rd === 5'd3); end
      end_cycle();
    end
    checks++;
    if (stalls != 9 || !started || !same)
      $display("FAIL raw_stall got stalls=%0d start=%0d wb_same=%0d exp 9/1/1", stalls, started, same);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      begin_idle();
      checks++;
      if (obs !== exp_v) $display("FAIL raw_drain i=%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      end_cycle();
    end
    #1;
    checks++;
    if (perf_stall_cnt !== perf_expected())
      $display("FAIL raw_perf got=%0d exp=%0d", perf_stall_cnt, perf_expected());
    else passed++;
  endtask

  task automatic test_waw();
    begin_cycle(1'b1, F_MUL, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end_cycle();
    begin_cycle(1'b0, 7'd0, 5'd6, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v || stall_id !== 1'b0)
      $display("FAIL int_no_stall got=%h exp=%h", obs, exp_v);
    else passed++;
    end_cycle();
    begin_cycle(1'b0, 7'd0, 5'd5, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_v || stall_id !== 1'b1)
      $display("FAIL flw_waw got=%h exp=%h", obs, exp_v);
    else passed++;
    end_cycle();
    for (int i = 0; i < 3; i++) begin
      begin_idle();
      checks++;
      if (obs !== exp_v) $display("FAIL waw_drain i=%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      end_cycle();
    end
  endtask

  task automatic test_flush();
    int wb_cnt = 0;
    begin_cycle(1'b1, F_SQRT, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end_cycle();
    for (int i = 1; i <= 16; i++) begin
      begin_cycle(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, (i == 10));
      checks++;
      if (obs !== exp_v) $display("FAIL flush_seq i=%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      if (i == 10) begin
        checks++;
        if (fpu_abort !== 1'b1) $display("FAIL flush_abort got=%0d exp=1", fpu_abort);
        else passed++;
      end
      if (i == 11) begin
        checks++;
        if (busy !== 1'b0) $display("FAIL flush_busy got=%0d exp=0", busy);
        else passed++;
      end
      if (wb_valid === 1'b1) wb_cnt++;
      end_cycle();
    end
    checks++;
    if (wb_cnt != 0) $display("FAIL flush_no_wb got=%0d exp=0", wb_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    begin_cycle(1'b1, F_ADD, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end_cycle();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 2) begin_cycle(1'b1, F_MUL, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      else begin_idle();
      checks++;
      if (obs !== exp_v) $display("FAIL b2b_seq i=%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      if (i == 2) begin
        checks++;
        if (fpu_start !== 1'b1 || wb_valid !== 1'b1 || wb_rd !== 5'd1 || fpu_op !== 2'd1)
          $display("FAIL b2b_zero_bubble got start=%0d wb=%0d rd=%0d exp 1/1/1", fpu_start, wb_valid, wb_rd);
        else passed++;
      end
      if (i == 5) begin
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd2)
          $display("FAIL b2b_mul_wb got wb=%0d rd=%0d exp 1/2", wb_valid, wb_rd);
        else passed++;
      end
      end_cycle();
    end
  endtask

  task automatic test_reset_mid();
    int wb_at = -1;
    begin_cycle(1'b1, F_DIV, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end_cycle();
    for (int i = 0; i < 4; i++) begin begin_idle(); end_cycle(); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (obs !== 12'h000 || perf_stall_cnt !== 32'd0)
      $display("FAIL reset_mid got=%h perf=%0d exp=000 perf=0", obs, perf_stall_cnt);
    else passed++;
    m_busy = 1'b0; exp_perf = 32'd0;
    @(posedge clk);
    cyc++;
    #2 rstn = 1'b1;
    begin_cycle(1'b1, F_ADD, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end_cycle();
    for (int i = 1; i <= 4; i++) begin
      begin_idle();
      checks++;
      if (obs !== exp_v) $display("FAIL reset_mid_seq i=%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      if (wb_valid === 1'b1 && wb_at < 0) wb_at = i;
      end_cycle();
    end
    checks++;
    if (wb_at != 2) $display("FAIL reset_mid_fadd got=%0d exp=2", wb_at); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      begin_cycle($urandom_range(0, 2) != 0, f7_tab[$urandom_range(0, 6)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0);
      checks++;
      if (obs !== exp_v) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      else passed++;
      end_cycle();
    end
    #1;
    checks++;
    if (perf_stall_cnt !== perf_expected())
      $display("FAIL random_perf got=%0d exp=%0d", perf_stall_cnt, perf_expected());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fdiv_latency();
    test_raw_stall();
    test_waw();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
